mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the RV32M extension; it sits beside the ALU in the execute stage.
- It accepts one M-type operation from decode, runs a radix-2 shift-add or shift-subtract loop, and stalls the CPU until the result is ready.
- It returns a 32-bit result for register writeback, with a start/busy/done handshake to the pipeline controller.

Parameters:
- XLEN, 32, operand/result width; the loop count equals XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value
- flush  in  1  abort current operation (branch taken/trap)
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  result; holds its value until the next done
- stall  out  1  freeze the PC/pipeline: (IDLE & start & ~flush) | CALC | FIX

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, stall=0, result=0, counter=0, all internal registers 0.
- States and transitions:
  - IDLE: on start & ~flush, latch op, |a|, |b| (signedness per op) and the result sign, then go to CALC (count=0). Special cases go directly to DONE instead.
  - CALC: one iteration per cycle, count increments; at count==XLEN-1 go to FIX.
  - FIX: apply sign correction and select the high/low/quotient/remainder word into result; go to DONE.
  - DONE: done=1, busy=0, stall=0; next state is IDLE. A start arriving in DONE is ignored; the CPU re-presents it in a later cycle.
- Latency: if start is sampled at edge N, done=1 during the cycle after edge N+33 (34 cycles total). For special cases, done=1 in the cycle after edge N.
- Special cases (RISC-V defined):
  - Divide by zero: div/divu → all ones; rem/remu → operand_a.
  - Signed overflow (a=0x8000_0000, b=0xFFFF_FFFF): div → 0x8000_0000, rem → 0.
- Multiply: 2*XLEN-bit accumulator.
  - mul returns the low word.
  - mulh/mulhsu/mulhu return the high word.
  - Negation is applied on the full 64-bit product.
- Divide: restoring algorithm on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncating division).
- Simultaneous events:
  - flush has priority over start and over any state. It forces IDLE on the next edge, no done pulse, and result is unchanged.
  - start while busy is ignored; operands are not re-latched.
- Reset mid-operation aborts immediately with no done pulse.
- Operands are latched at start, so later changes on operand_a/operand_b have no effect.

Decomposition:
- Shared package mdu_pkg:
  - op encodings (MDU_MUL … MDU_REMU)
  - state encoding (S_IDLE, S_CALC, S_FIX, S_DONE)
  - XLEN default
  - special-case constants (DIV0_Q = all ones, OVF_DIVIDEND = 0x8000_0000)
- One natural sub-module, mdu_datapath, holds the accumulator/quotient shift registers and the add/subtract step. mdu_seq keeps the FSM, counter, special-case detection and sign fix.

Test Plan:
- mul a=7, b=0xFFFF_FFFD (−3), start one cycle → done exactly 34 cycles later, result=0xFFFF_FFEB; stall high for 33 cycles and low in the done cycle.
- mulhu a=b=0xFFFF_FFFF → result 0xFFFF_FFFE. mulh same operands → 0x0000_0000. mulhsu a=0xFFFF_FFFF, b=2 → 0xFFFF_FFFF.
- div a=0xFFFF_FFF9 (−7), b=2 → 0xFFFF_FFFD (−3). rem same operands → 0xFFFF_FFFF (−1). divu 100/7 → 14. remu 100/7 → 2.
- divu a=0x1234, b=0 → done one cycle after start, result 0xFFFF_FFFF. remu same operands → 0x1234. div 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000, done after 1 cycle.
- Start a div, then at cycle 10:
  - pulse start with new operands → ignored, original result still produced.
  - separately, assert flush at cycle 10 → IDLE next edge, no done, result retains its prior value.
- Drop rst_n at cycle 5 of CALC → busy/stall/done=0 and result=0 immediately (asynchronous). After release, a fresh mul 3*4 → 12 at 34 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package mdu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

    localparam logic [XLEN-1:0] DIV0_Q       = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic op_a_signed(mdu_op_e op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_b_signed(mdu_op_e op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Pipeline-controller-to-MDU request/result bundle.
// Latency: none (wires only).
// Backpressure: the MDU raises stall until its result is ready.
interface mdu_seq_if #(parameter int XLEN = mdu_pkg::XLEN);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  busy, done, result, stall
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output busy, done, result, stall
    );
endinterface

// File: rtl/mdu_datapath.sv
// Radix-2 shift-add multiply / restoring divide on unsigned magnitudes.
// Latency: one iteration per step cycle; XLEN steps give the full result.
// Backpressure: none; the sequencer owns load/step timing.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int XLEN = mdu_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic              div_q;

    logic [XLEN:0]     sum;
    logic [XLEN:0]     rshift;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;

    // Multiply: hi += multiplicand when the lsb of the multiplier is set, then shift right.
    assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    assign mul_next = {sum, acc_q[XLEN-1:1]};

    // Divide: hi holds the partial remainder, lo shifts the dividend out and quotient in.
    assign rshift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign diff     = rshift - {1'b0, opnd_q};
    assign div_next = diff[XLEN] ? {rshift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else if (load) begin
            div_q  <= is_div;
            opnd_q <= is_div ? b_mag : a_mag;
            acc_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        end else if (step) begin
            acc_q  <= div_q ? div_next : mul_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mdu_seq.sv
// RV32M multiply/divide sequencer: FSM, special cases and sign fix-up.
// Latency: 34 cycles start-to-done; 1 cycle for divide-by-zero/overflow.
// Backpressure: stall holds the pipeline; start is only taken in IDLE.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = mdu_pkg::XLEN
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN);

    mdu_state_e        state;
    logic [CNT_W-1:0]  count;
    mdu_op_e           op_q;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   result_q;
    logic              done_q;
    logic              busy_q;

    mdu_op_e           op_in;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic              accept;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;

    assign op_in  = mdu_op_e'(bus.op);
    assign a_neg  = op_a_signed(op_in) & bus.operand_a[XLEN-1];
    assign b_neg  = op_b_signed(op_in) & bus.operand_b[XLEN-1];
    assign a_mag  = a_neg ? -bus.operand_a : bus.operand_a;
    assign b_mag  = b_neg ? -bus.operand_b : bus.operand_b;

    assign div_zero = bus.op[2] && (bus.operand_b == '0);
    assign div_ovf  = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                      (bus.operand_a == OVF_DIVIDEND) && (bus.operand_b == DIV0_Q);
    assign special  = div_zero | div_ovf;

    // op[1] separates rem/remu from div/divu within the divide group.
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = bus.op[1] ? bus.operand_a : DIV0_Q;
        else if (div_ovf)
            special_res = bus.op[1] ? '0 : OVF_DIVIDEND;
    end

    assign accept = (state == S_IDLE) && bus.start && !bus.flush;

    mdu_datapath #(.XLEN(XLEN)) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept && !special),
        .step   (state == S_CALC),
        .is_div (bus.op[2]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    // Products are negated as a full double word so mulh* sees the borrow.
    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = '0;
        case (op_q)
            MDU_MUL:                      fix_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU,
            MDU_MULHU:                    fix_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:            fix_res = quo;
            MDU_REM, MDU_REMU:            fix_res = rem;
            default:                      fix_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            op_q     <= MDU_MUL;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (bus.flush) begin
            state  <= S_IDLE;
            count  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            op_q   <= op_in;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            count  <= '0;
                            busy_q <= 1'b1;
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    count <= count + 1'b1;
                    if (count == CNT_W'(XLEN-1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_res;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.stall  = accept || (state == S_CALC) || (state == S_FIX);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed and randomized checks of mdu_seq against an arithmetic reference.
module tb_mdu_seq;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [31:0] last_exp;

    mdu_seq_if ifc ();

    mdu_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        logic signed [31:0] sa32, sb32, q;
        logic ovf;
        sa   = {{32{a[31]}}, a};
        ua   = {32'b0, a};
        sb   = {{32{b[31]}}, b};
        ub   = {32'b0, b};
        sa32 = a;
        sb32 = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                q = sa32 / sb32;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = sa32 % sb32;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return op[2] && ((b == 0) ||
               ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Issue one operation from IDLE and check latency, stall/busy, result and done pulse.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        int bad;
        int exp_lat;
        exp_lat = is_special(op, a, b) ? 0 : 33;
        ifc.op        = op;
        ifc.operand_a = a;
        ifc.operand_b = b;
        ifc.start     = 1'b1;
        #1;
        chk({tag, " stall_req"}, 32'(ifc.stall), 32'd1);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        cyc = 0;
        bad = 0;
        while (ifc.done !== 1'b1 && cyc < 100) begin
            if (ifc.stall !== 1'b1 || ifc.busy !== 1'b1) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " stall_busy_calc"}, 32'(bad), 32'd0);
        chk({tag, " result"}, ifc.result, exp);
        chk({tag, " stall_done"}, 32'(ifc.stall), 32'd0);
        chk({tag, " busy_done"}, 32'(ifc.busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 32'(ifc.done), 32'd0);
        chk({tag, " result_hold"}, ifc.result, exp);
        last_exp = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        int dones;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        tests = 0;
        fails = 0;
        last_exp = 0;
        clk = 0;
        rst_n = 0;
        ifc.start = 0;
        ifc.op = 0;
        ifc.operand_a = 0;
        ifc.operand_b = 0;
        ifc.flush = 0;

        #3;
        chk("reset busy", 32'(ifc.busy), 32'd0);
        chk("reset done", 32'(ifc.done), 32'd0);
        chk("reset stall", 32'(ifc.stall), 32'd0);
        chk("reset result", ifc.result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        run_op("mul 7*-3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu -1*-1",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh -1*-1",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu -1*2",   3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
        run_op("div -7/2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem -7/2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu 100/7",    3'd5, 32'd100,        32'd7,         32'd14);
        run_op("remu 100/7",    3'd7, 32'd100,        32'd7,         32'd2);
        run_op("divu by0",      3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF);
        run_op("remu by0",      3'd7, 32'h1234,       32'd0,         32'h1234);
        run_op("div ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0);
        run_op("div by0",       3'd4, 32'h8000_0001,  32'd0,         32'hFFFF_FFFF);
        run_op("rem by0",       3'd6, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_op("random", rop, ra, rb, model(rop, ra, rb));
        end

        // Start while busy, with operands changing under it: original request wins.
        ifc.op = 3'd4; ifc.operand_a = 32'd1000; ifc.operand_b = 32'd7; ifc.start = 1;
        @(posedge clk); #1;
        ifc.start = 0;
        cyc = 0;
        while (ifc.done !== 1'b1 && cyc < 100) begin
            if (cyc == 10) begin
                ifc.start = 1; ifc.op = 3'd5; ifc.operand_a = 32'd5; ifc.operand_b = 32'd1;
            end else begin
                ifc.start = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ifc.start = 0;
        chk("busy_start latency", 32'(cyc), 32'd33);
        chk("busy_start result", ifc.result, 32'd142);
        last_exp = 32'd142;
        @(posedge clk); #1;

        // Flush mid-divide: no done pulse, result untouched.
        ifc.op = 3'd4; ifc.operand_a = 32'd999; ifc.operand_b = 32'd3; ifc.start = 1;
        @(posedge clk); #1;
        ifc.start = 0;
        repeat (10) @(posedge clk);
        #1;
        ifc.flush = 1;
        @(posedge clk); #1;
        ifc.flush = 0;
        chk("flush busy", 32'(ifc.busy), 32'd0);
        chk("flush stall", 32'(ifc.stall), 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        chk("flush no_done", 32'(dones), 32'd0);
        chk("flush result", ifc.result, last_exp);

        // Asynchronous reset in the middle of CALC.
        ifc.op = 3'd0; ifc.operand_a = 32'd9; ifc.operand_b = 32'd9; ifc.start = 1;
        @(posedge clk); #1;
        ifc.start = 0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("arst busy", 32'(ifc.busy), 32'd0);
        chk("arst stall", 32'(ifc.stall), 32'd0);
        chk("arst done", 32'(ifc.done), 32'd0);
        chk("arst result", ifc.result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        run_op("mul 3*4 after reset", 3'd0, 32'd3, 32'd4, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
